// File: rtl/blackparrot_fpga_host_pkg.sv
// Shared register offsets, AXI response codes and FSM state types
// for the host AXI-Lite to flit FIFO bridge.
package blackparrot_fpga_host_pkg;

    localparam logic [5:0] e_host_reg_push    = 6'h00;
    localparam logic [5:0] e_host_reg_vacancy = 6'h01;
    localparam logic [5:0] e_host_reg_count   = 6'h02;

    typedef enum logic [1:0] {
        e_axi_okay   = 2'b00,
        e_axi_slverr = 2'b10
    } axi_resp_e;

    typedef enum logic [1:0] {
        e_collect,
        e_push,
        e_resp
    } wr_state_e;

    typedef enum logic {
        e_ridle,
        e_rresp
    } rd_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO, one write and one read port.
// No bypass: a flit written this cycle is visible next cycle.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 32,
    parameter int els_p   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    v_i,
    input  logic [width_p-1:0]      data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [width_p-1:0]      data_o,
    input  logic                    yumi_i,
    output logic [$clog2(els_p):0]  count_o
);
    localparam int ptr_w = $clog2(els_p);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   wptr, rptr;
    logic [ptr_w:0]     count;
    logic               enq, deq;

    // readiness is judged on the current count, so a same-cycle
    // dequeue never makes room for a same-cycle enqueue
    assign ready_o = (count != (ptr_w+1)'(els_p));
    assign v_o     = (count != '0);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign data_o  = mem[rptr];
    assign count_o = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq) wptr <= wptr + 1'b1;
            if (deq) rptr <= rptr + 1'b1;
            count <= count + (ptr_w+1)'(enq) - (ptr_w+1)'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem[wptr] <= data_i;
    end

endmodule

// File: rtl/blackparrot_fpga_host_axil_to_fifo.sv
// AXI4-Lite slave that turns host word writes into 32b flits for the
// NBF deserializer and exposes vacancy / pushed-word status for reads.
module blackparrot_fpga_host_axil_to_fifo
    import blackparrot_fpga_host_pkg::*;
#(
    parameter int S_AXIL_ADDR_WIDTH = 32,
    parameter int S_AXIL_DATA_WIDTH = 32,
    parameter int fifo_els_p        = 16
) (
    input  logic                           s_axil_aclk,
    input  logic                           s_axil_aresetn,
    input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                           s_axil_awvalid,
    output logic                           s_axil_awready,
    input  logic [2:0]                     s_axil_awprot,
    input  logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [S_AXIL_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                           s_axil_wvalid,
    output logic                           s_axil_wready,
    output logic [1:0]                     s_axil_bresp,
    output logic                           s_axil_bvalid,
    input  logic                           s_axil_bready,
    input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                           s_axil_arvalid,
    output logic                           s_axil_arready,
    input  logic [2:0]                     s_axil_arprot,
    output logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                     s_axil_rresp,
    output logic                           s_axil_rvalid,
    input  logic                           s_axil_rready,
    output logic                           fifo_v_o,
    output logic [S_AXIL_DATA_WIDTH-1:0]   fifo_data_o,
    input  logic                           fifo_ready_and_i
);
    localparam int D  = S_AXIL_DATA_WIDTH;
    localparam int CW = $clog2(fifo_els_p) + 1;

    logic                ready_en;
    wr_state_e           wr_state;
    rd_state_e           rd_state;
    logic                aw_full, w_full;
    logic [5:0]          aw_reg;
    logic [D-1:0]        wdata_r;
    logic [D/8-1:0]      wstrb_r;
    logic [D-1:0]        push_count;
    logic [CW-1:0]       occ;
    logic                fifo_ready, enq;
    logic                aw_hs, w_hs, ar_hs, wr_legal;
    logic [D-1:0]        vacancy, rd_data_n;
    axi_resp_e           bresp_r, rresp_r, rd_resp_n;

    assign s_axil_awready = ready_en & ~aw_full & (wr_state == e_collect);
    assign s_axil_wready  = ready_en & ~w_full & (wr_state == e_collect);
    assign s_axil_arready = ready_en & (rd_state == e_ridle);
    assign s_axil_bresp   = bresp_r;
    assign s_axil_rresp   = rresp_r;

    assign aw_hs    = s_axil_awvalid & s_axil_awready;
    assign w_hs     = s_axil_wvalid & s_axil_wready;
    assign ar_hs    = s_axil_arvalid & s_axil_arready;
    assign wr_legal = (aw_reg == e_host_reg_push) & (&wstrb_r);
    assign enq      = (wr_state == e_push) & wr_legal & fifo_ready;
    assign vacancy  = D'(fifo_els_p) - D'(occ);

    logic unused;
    assign unused = ^{s_axil_awprot, s_axil_arprot,
                      s_axil_awaddr[S_AXIL_ADDR_WIDTH-1:8], s_axil_awaddr[1:0],
                      s_axil_araddr[S_AXIL_ADDR_WIDTH-1:8], s_axil_araddr[1:0]};

    bsg_fifo_1r1w_small #(.width_p(D), .els_p(fifo_els_p)) fifo (
        .clk     (s_axil_aclk),
        .rst_n   (s_axil_aresetn),
        .v_i     (enq),
        .data_i  (wdata_r),
        .ready_o (fifo_ready),
        .v_o     (fifo_v_o),
        .data_o  (fifo_data_o),
        .yumi_i  (fifo_v_o & fifo_ready_and_i),
        .count_o (occ)
    );

    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
        if (!s_axil_aresetn) ready_en <= 1'b0;
        else                 ready_en <= 1'b1;
    end

    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
        if (!s_axil_aresetn) begin
            wr_state      <= e_collect;
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            aw_reg        <= '0;
            wdata_r       <= '0;
            wstrb_r       <= '0;
            s_axil_bvalid <= 1'b0;
            bresp_r       <= e_axi_okay;
            push_count    <= '0;
        end else begin
            if (enq) push_count <= push_count + 1'b1;
            unique case (wr_state)
                e_collect: begin
                    if (aw_hs) begin
                        aw_full <= 1'b1;
                        aw_reg  <= s_axil_awaddr[7:2];
                    end
                    if (w_hs) begin
                        w_full  <= 1'b1;
                        wdata_r <= s_axil_wdata;
                        wstrb_r <= s_axil_wstrb;
                    end
                    if ((aw_full | aw_hs) & (w_full | w_hs))
                        wr_state <= e_push;
                end
                // error writes never wait on FIFO space
                e_push: begin
                    if (!wr_legal || fifo_ready) begin
                        wr_state      <= e_resp;
                        s_axil_bvalid <= 1'b1;
                        bresp_r       <= wr_legal ? e_axi_okay : e_axi_slverr;
                    end
                end
                e_resp: begin
                    if (s_axil_bready) begin
                        s_axil_bvalid <= 1'b0;
                        aw_full       <= 1'b0;
                        w_full        <= 1'b0;
                        wr_state      <= e_collect;
                    end
                end
                default: wr_state <= e_collect;
            endcase
        end
    end

    always_comb begin
        rd_data_n = '0;
        rd_resp_n = e_axi_okay;
        unique case (s_axil_araddr[7:2])
            e_host_reg_push:    rd_data_n = '0;
            e_host_reg_vacancy: rd_data_n = vacancy;
            e_host_reg_count:   rd_data_n = push_count;
            default:            rd_resp_n = e_axi_slverr;
        endcase
    end

    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
        if (!s_axil_aresetn) begin
            rd_state      <= e_ridle;
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            rresp_r       <= e_axi_okay;
        end else begin
            unique case (rd_state)
                e_ridle: begin
                    if (ar_hs) begin
                        s_axil_rdata  <= rd_data_n;
                        rresp_r       <= rd_resp_n;
                        s_axil_rvalid <= 1'b1;
                        rd_state      <= e_rresp;
                    end
                end
                e_rresp: begin
                    if (s_axil_rready) begin
                        s_axil_rvalid <= 1'b0;
                        rd_state      <= e_ridle;
                    end
                end
                default: rd_state <= e_ridle;
            endcase
        end
    end

endmodule

// File: tb/tb_blackparrot_fpga_host_axil_to_fifo.sv
// Directed bench for the host AXI-Lite to flit FIFO bridge.
module tb_blackparrot_fpga_host_axil_to_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr, wdata, araddr, rdata, fifo_data;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        fifo_v, fifo_ready;

    int          vectors = 0;
    int          errs    = 0;
    logic [31:0] popped[$];

    always #5 clk = ~clk;

    blackparrot_fpga_host_axil_to_fifo dut (
        .s_axil_aclk      (clk),
        .s_axil_aresetn   (rst_n),
        .s_axil_awaddr    (awaddr),
        .s_axil_awvalid   (awvalid),
        .s_axil_awready   (awready),
        .s_axil_awprot    (awprot),
        .s_axil_wdata     (wdata),
        .s_axil_wstrb     (wstrb),
        .s_axil_wvalid    (wvalid),
        .s_axil_wready    (wready),
        .s_axil_bresp     (bresp),
        .s_axil_bvalid    (bvalid),
        .s_axil_bready    (bready),
        .s_axil_araddr    (araddr),
        .s_axil_arvalid   (arvalid),
        .s_axil_arready   (arready),
        .s_axil_arprot    (arprot),
        .s_axil_rdata     (rdata),
        .s_axil_rresp     (rresp),
        .s_axil_rvalid    (rvalid),
        .s_axil_rready    (rready),
        .fifo_v_o         (fifo_v),
        .fifo_data_o      (fifo_data),
        .fifo_ready_and_i (fifo_ready)
    );

    always @(negedge clk)
        if (rst_n && fifo_v && fifo_ready) popped.push_back(fifo_data);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pop_at(input int i);
        if (i < popped.size()) return popped[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_aw_w(input logic [31:0] a, d, input logic [3:0] s);
        logic aw_a, w_a;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 60 && (awvalid || wvalid); i++) begin
            @(negedge clk);
            aw_a = awvalid & awready;
            w_a  = wvalid & wready;
            @(posedge clk); #1;
            if (aw_a) awvalid = 1'b0;
            if (w_a)  wvalid  = 1'b0;
        end
        check("aw_w_accept", {30'b0, awvalid, wvalid}, 32'h0);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        logic got;
        got = 1'b0; resp = 2'b11; bready = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bvalid) begin got = 1'b1; resp = bresp; end
        end
        check("b_timeout", {31'b0, got}, 32'h1);
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic write(input logic [31:0] a, d, input logic [3:0] s,
                         output logic [1:0] resp);
        send_aw_w(a, d, s);
        wait_b(resp);
    endtask

    task automatic ar_handshake(input logic [31:0] a);
        logic acc;
        acc = 1'b0; araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 60 && !acc; i++) begin
            @(negedge clk);
            acc = arready;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        check("ar_accept", {31'b0, acc}, 32'h1);
    endtask

    task automatic read(input logic [31:0] a, output logic [31:0] d,
                        output logic [1:0] resp);
        logic got;
        got = 1'b0; d = 'x; resp = 2'b11;
        rready = 1'b1;
        ar_handshake(a);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (rvalid) begin got = 1'b1; d = rdata; resp = rresp; end
        end
        check("r_timeout", {31'b0, got}, 32'h1);
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    logic [1:0]  r;
    logic [31:0] d;
    int          bad;
    logic        seen;

    initial begin
        rst_n = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        fifo_ready = 0;
        #22;
        check("rst_readys", {29'b0, awready, wready, arready}, 32'h0);
        check("rst_valids", {29'b0, bvalid, rvalid, fifo_v}, 32'h0);
        check("rst_resp", {28'b0, bresp, rresp}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("ready_en_gate", {31'b0, awready}, 32'h0);
        cycles(1);
        check("ready_en_set", {29'b0, awready, wready, arready}, 32'h7);

        // basic push with consumer ready
        fifo_ready = 1'b1;
        popped.delete();
        write(32'h0, 32'hDEAD_BEEF, 4'hF, r);
        check("t1_bresp", {30'b0, r}, 32'h0);
        cycles(2);
        check("t1_nflits", popped.size(), 32'd1);
        check("t1_flit", pop_at(0), 32'hDEAD_BEEF);
        read(32'h8, d, r);
        check("t1_count", d, 32'd1);
        check("t1_rresp", {30'b0, r}, 32'h0);

        // fill with consumer stalled, 17th write waits for space
        fifo_ready = 1'b0;
        popped.delete();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            write(32'h0, 32'h100 + i, 4'hF, r);
            if (r !== 2'b00) bad++;
        end
        check("t2_16_okay", bad, 32'd0);
        read(32'h4, d, r);
        check("t2_vac_full", d, 32'd0);
        send_aw_w(32'h0, 32'h110, 4'hF);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bvalid) seen = 1'b1;
        end
        check("t2_17th_withheld", {31'b0, seen}, 32'h0);
        check("t2_fifo_v", {31'b0, fifo_v}, 32'h1);
        @(posedge clk); #1;
        fifo_ready = 1'b1;
        @(posedge clk); #1;
        fifo_ready = 1'b0;
        wait_b(r);
        check("t2_17th_bresp", {30'b0, r}, 32'h0);
        read(32'h4, d, r);
        check("t2_vac_after", d, 32'd0);
        read(32'h8, d, r);
        check("t2_count", d, 32'd18);
        fifo_ready = 1'b1;
        cycles(20);
        check("t2_nflits", popped.size(), 32'd17);
        bad = 0;
        for (int i = 0; i < 17; i++)
            if (pop_at(i) !== 32'h100 + i) bad++;
        check("t2_order", bad, 32'd0);

        // W three cycles ahead of AW, then AW and W together
        popped.delete();
        wdata = 32'h33; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        check("t3_wready", {31'b0, wready}, 32'h1);
        @(posedge clk); #1;
        wvalid = 1'b0;
        cycles(2);
        check("t3_no_early_b", {31'b0, bvalid}, 32'h0);
        awaddr = 32'h0; awvalid = 1'b1;
        @(negedge clk);
        check("t3_awready", {31'b0, awready}, 32'h1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wait_b(r);
        check("t3_w_first_bresp", {30'b0, r}, 32'h0);
        write(32'h0, 32'h44, 4'hF, r);
        check("t3_same_cycle_bresp", {30'b0, r}, 32'h0);
        cycles(3);
        check("t3_nflits", popped.size(), 32'd2);
        check("t3_flit0", pop_at(0), 32'h33);
        check("t3_flit1", pop_at(1), 32'h44);

        // error writes and reads
        popped.delete();
        write(32'hC, 32'h55, 4'hF, r);
        check("t4_bad_addr", {30'b0, r}, 32'h2);
        write(32'h0, 32'h56, 4'h3, r);
        check("t4_bad_strb", {30'b0, r}, 32'h2);
        write(32'h4, 32'h57, 4'hF, r);
        check("t4_wr_status", {30'b0, r}, 32'h2);
        cycles(3);
        check("t4_no_flit", popped.size(), 32'd0);
        read(32'h8, d, r);
        check("t4_count", d, 32'd20);
        read(32'h10, d, r);
        check("t4_rd_bad_data", d, 32'h0);
        check("t4_rd_bad_resp", {30'b0, r}, 32'h2);
        read(32'h100, d, r);
        check("t4_alias_push_data", d, 32'h0);
        check("t4_alias_push_resp", {30'b0, r}, 32'h0);

        // held read response alongside a write
        fifo_ready = 1'b0;
        fork
            begin
                int unstable;
                unstable = 0;
                rready = 1'b0;
                ar_handshake(32'h4);
                repeat (5) begin
                    @(negedge clk);
                    if (!(rvalid === 1'b1 && rdata === 32'd16 &&
                          rresp === 2'b00)) unstable++;
                end
                check("t5_r_stable", unstable, 32'd0);
                rready = 1'b1;
                @(posedge clk); #1;
                rready = 1'b0;
            end
            begin
                write(32'h0, 32'h66, 4'hF, r);
                check("t5_conc_bresp", {30'b0, r}, 32'h0);
            end
        join
        check("t5_rvalid_drop", {31'b0, rvalid}, 32'h0);
        read(32'h4, d, r);
        check("t5_vac", d, 32'd15);
        read(32'h8, d, r);
        check("t5_count", d, 32'd21);

        // counter wrap and reset during a stalled push
        fifo_ready = 1'b1;
        cycles(3);
        force dut.push_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.push_count;
        cycles(1);
        read(32'h8, d, r);
        check("t6_preload", d, 32'hFFFF_FFFF);
        write(32'h0, 32'h77, 4'hF, r);
        read(32'h8, d, r);
        check("t6_wrap", d, 32'h0);
        cycles(3);
        fifo_ready = 1'b0;
        for (int i = 0; i < 16; i++) write(32'h0, 32'h200 + i, 4'hF, r);
        send_aw_w(32'h0, 32'h299, 4'hF);
        cycles(2);
        check("t6_stalled", {30'b0, fifo_v, bvalid}, 32'h2);
        rst_n = 1'b0;
        #2;
        check("t6_rst_valids", {29'b0, bvalid, rvalid, fifo_v}, 32'h0);
        check("t6_rst_readys", {29'b0, awready, wready, arready}, 32'h0);
        check("t6_rst_resp", {28'b0, bresp, rresp}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(2);
        read(32'h4, d, r);
        check("t6_vac_after_rst", d, 32'd16);
        read(32'h8, d, r);
        check("t6_count_after_rst", d, 32'd0);
        check("t6_quiet", {30'b0, bvalid, fifo_v}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
